// File: rtl/memory_stage.sv
// Data-memory stage: 1024 x 64-bit doubleword memory with synchronous stores,
// combinational loads, and straight pass-through of the write-back control fields.
module memory_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] ALUResult,
    input  logic [63:0] WriteData,
    input  logic [4:0]  Rd,
    input  logic        Zero,
    input  logic        BranchTaken,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    output logic [63:0] ReadData,
    output logic [63:0] ALUResultOut,
    output logic [4:0]  RdOut,
    output logic        BranchTakenOut,
    output logic        MemtoRegOut,
    output logic        RegWriteOut
);

    logic [63:0] mem [0:1023];
    logic [9:0]  mem_index;
    logic        in_range;
    logic        unused_zero;

    // The branch is already resolved upstream, so the zero flag is only accepted.
    assign unused_zero = Zero;

    // Low three address bits select a byte within the doubleword and are dropped.
    assign mem_index = ALUResult[12:3];
    assign in_range  = (ALUResult[63:13] == 51'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i] <= 64'd0;
            end
        end else if (MemWrite && in_range) begin
            mem[mem_index] <= WriteData;
        end
    end

    assign ReadData       = (MemRead && reset && in_range) ? mem[mem_index] : 64'd0;
    assign ALUResultOut   = ALUResult;
    assign RdOut          = Rd;
    assign BranchTakenOut = BranchTaken;
    assign MemtoRegOut    = MemtoReg;
    assign RegWriteOut    = RegWrite;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed test-plan steps followed by random accesses,
// checked against a sparse doubleword-keyed memory model.
module tb_memory_stage;

    logic        clk;
    logic        reset;
    logic [63:0] alu_result;
    logic [63:0] write_data;
    logic [4:0]  rd;
    logic        zero;
    logic        branch_taken;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic [63:0] read_data;
    logic [63:0] alu_result_out;
    logic [4:0]  rd_out;
    logic        branch_taken_out;
    logic        mem_to_reg_out;
    logic        reg_write_out;

    int total = 0;
    int bad   = 0;

    // Unwritten (or cleared) doublewords are simply absent and read as zero.
    logic [63:0] model [logic [63:0]];

    memory_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ALUResult      (alu_result),
        .WriteData      (write_data),
        .Rd             (rd),
        .Zero           (zero),
        .BranchTaken    (branch_taken),
        .MemRead        (mem_read),
        .MemWrite       (mem_write),
        .MemtoReg       (mem_to_reg),
        .RegWrite       (reg_write),
        .ReadData       (read_data),
        .ALUResultOut   (alu_result_out),
        .RdOut          (rd_out),
        .BranchTakenOut (branch_taken_out),
        .MemtoRegOut    (mem_to_reg_out),
        .RegWriteOut    (reg_write_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] exp_read();
        logic [63:0] key;
        if (!(mem_read && reset && alu_result < 64'h2000)) return 64'd0;
        key = alu_result & ~64'h7;
        return model.exists(key) ? model[key] : 64'd0;
    endfunction

    task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [4:0] rd_i, input logic br, input logic mr, input logic mw);
        reset        = rst;
        alu_result   = addr;
        write_data   = wdata;
        rd           = rd_i;
        branch_taken = br;
        mem_read     = mr;
        mem_write    = mw;
        zero         = 1'($urandom());
        mem_to_reg   = 1'($urandom());
        reg_write    = 1'($urandom());
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, "_read"},   read_data, exp_read());
        checkValue({tag, "_alu"},    alu_result_out, alu_result);
        checkValue({tag, "_rd"},     64'(rd_out), 64'(rd));
        checkValue({tag, "_branch"}, 64'(branch_taken_out), 64'(branch_taken));
        checkValue({tag, "_m2r"},    64'(mem_to_reg_out), 64'(mem_to_reg));
        checkValue({tag, "_regw"},   64'(reg_write_out), 64'(reg_write));
    endtask

    // Advance one rising edge and apply the same edge's effect to the model.
    task automatic clockEdge();
        @(posedge clk);
        if (!reset) model.delete();
        else if (mem_write && alu_result < 64'h2000) model[alu_result & ~64'h7] = write_data;
        #1;
    endtask

    initial begin
        logic [63:0] addr;
        logic        rst;

        @(negedge clk);
        applyStimulus(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("reset_low");
        checkValue("reset_low_const", read_data, 64'd0);
        clockEdge();
        applyStimulus(1'b1, 64'h1FF8, 64'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("post_reset");

        applyStimulus(1'b1, 64'h10, 64'hDEADBEEFDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1);
        clockEdge();
        applyStimulus(1'b1, 64'h10, 64'h0, 5'd13, 1'b0, 1'b1, 1'b0);
        checkOutput("load10");
        checkValue("load10_const", read_data, 64'hDEADBEEFDEADBEEF);
        checkValue("load10_rdout", 64'(rd_out), 64'd13);

        applyStimulus(1'b1, 64'h20, 64'h1234567890ABCDEF, 5'd4, 1'b0, 1'b0, 1'b1);
        clockEdge();
        applyStimulus(1'b1, 64'h20, 64'h0, 5'd4, 1'b0, 1'b1, 1'b0);
        checkOutput("load20");
        checkValue("load20_const", read_data, 64'h1234567890ABCDEF);
        applyStimulus(1'b1, 64'h10, 64'h0, 5'd4, 1'b0, 1'b1, 1'b0);
        checkValue("load10_kept", read_data, 64'hDEADBEEFDEADBEEF);

        applyStimulus(1'b1, 64'h30, 64'h0, 5'd7, 1'b1, 1'b0, 1'b0);
        checkOutput("branch");
        checkValue("branch_read", read_data, 64'd0);
        checkValue("branch_out", 64'(branch_taken_out), 64'd1);
        checkValue("branch_alu", alu_result_out, 64'h30);

        applyStimulus(1'b1, 64'h0, 64'hAAAAAAAAAAAAAAAA, 5'd1, 1'b0, 1'b0, 1'b1);
        clockEdge();
        applyStimulus(1'b1, 64'h1FF8, 64'h5555555555555555, 5'd1, 1'b0, 1'b0, 1'b1);
        clockEdge();
        applyStimulus(1'b1, 64'h0, 64'h0, 5'd1, 1'b0, 1'b1, 1'b0);
        checkValue("bound_low", read_data, 64'hAAAAAAAAAAAAAAAA);
        applyStimulus(1'b1, 64'h1FF8, 64'h0, 5'd1, 1'b0, 1'b1, 1'b0);
        checkValue("bound_high", read_data, 64'h5555555555555555);
        applyStimulus(1'b1, 64'h2000, 64'h0123012301230123, 5'd1, 1'b0, 1'b1, 1'b1);
        checkValue("oor_read", read_data, 64'd0);
        clockEdge();
        applyStimulus(1'b1, 64'h0, 64'h0, 5'd1, 1'b0, 1'b1, 1'b0);
        checkValue("oor_no_alias", read_data, 64'hAAAAAAAAAAAAAAAA);

        applyStimulus(1'b1, 64'h10, 64'hFFFFFFFFFFFFFFFF, 5'd2, 1'b0, 1'b0, 1'b1);
        clockEdge();
        applyStimulus(1'b0, 64'h10, 64'h1111111111111111, 5'd2, 1'b0, 1'b1, 1'b1);
        checkValue("reset_read", read_data, 64'd0);
        clockEdge();
        applyStimulus(1'b1, 64'h10, 64'h0, 5'd2, 1'b0, 1'b1, 1'b0);
        checkOutput("after_reset");
        checkValue("after_reset_const", read_data, 64'd0);

        applyStimulus(1'b1, 64'h13, 64'hCAFEF00D12345678, 5'd3, 1'b0, 1'b0, 1'b1);
        clockEdge();
        applyStimulus(1'b1, 64'h10, 64'h0, 5'd3, 1'b0, 1'b1, 1'b0);
        checkValue("misaligned", read_data, 64'hCAFEF00D12345678);

        applyStimulus(1'b1, 64'h48, 64'h0BADC0DE0BADC0DE, 5'd5, 1'b0, 1'b1, 1'b1);
        checkValue("rw_before", read_data, 64'd0);
        clockEdge();
        checkValue("rw_after", read_data, 64'h0BADC0DE0BADC0DE);
        checkOutput("rw_after_model");

        // Random traffic concentrated on a few doublewords so writes and reads collide.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) addr = {$urandom(), $urandom()} | 64'h2000;
            else addr = 64'($urandom_range(0, 255));
            rst = ($urandom_range(0, 49) != 0);
            applyStimulus(rst, addr, {$urandom(), $urandom()}, 5'($urandom()),
                          1'($urandom()), 1'($urandom()), 1'($urandom()));
            checkOutput("rand");
            clockEdge();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Data-memory stage of the sequential RV64 processor, between execute and write-back. Holds a 1024 × 64-bit doubleword data memory, performs loads and stores addressed by the ALU result, and forwards the write-back control and destination fields unchanged to the write-back stage. Stores are synchronous. Loads are combinational.

## Interface
- No parameters. Depth is fixed at 1024 doublewords (8 KiB) and width at 64 bits.
- clk  input  1  single clock; all state updates occur on its rising edge
- reset  input  1  reset is synchronous and active-low; clears the entire data memory
- ALUResult  input  64  byte address for load/store; also forwarded
- WriteData  input  64  store data (rs2 value)
- Rd  input  5  destination register index
- Zero  input  1  ALU zero flag; accepted but unused (branch already resolved in BranchTaken)
- BranchTaken  input  1  resolved branch decision
- MemRead  input  1  load enable
- MemWrite  input  1  store enable
- MemtoReg  input  1  write-back select
- RegWrite  input  1  register-file write enable
- ReadData  output  64  load data
- ALUResultOut  output  64  = ALUResult
- RdOut  output  5  = Rd
- BranchTakenOut  output  1  = BranchTaken
- MemtoRegOut  output  1  = MemtoReg
- RegWriteOut  output  1  = RegWrite

## Operation
- **Addressing**
  - Doubleword index = ALUResult[12:3].
  - ALUResult[2:0] is ignored, so misaligned addresses are truncated to the containing doubleword.
  - An address is in range iff ALUResult[63:13] == 0, i.e. ALUResult < 0x2000.
- **Store**
  - On a rising clk edge with reset high, MemWrite = 1 and the address in range: mem[index] <= WriteData.
  - A store to an out-of-range address is silently dropped; memory is unchanged.
- **Load**
  - ReadData = mem[index] when MemRead = 1, reset is high and the address is in range.
  - Otherwise ReadData = 64'h0. This covers MemRead = 0, out-of-range addresses and reset low.
- **Pass-through**
  - ALUResultOut, RdOut, BranchTakenOut, MemtoRegOut and RegWriteOut are pure combinational copies of their inputs, independent of reset and memory activity.
- **Reset**
  - On a rising edge with reset low, all 1024 entries are set to 0 in that single edge.
  - Reset has priority over a simultaneous store.
- **No error reporting**
  - There is no error flag for out-of-range accesses.

## Timing
- **Load latency**: zero cycles (combinational from ALUResult/MemRead to ReadData).
- **Store latency**: data is visible to a load starting the cycle after the write edge.
- **Same-cycle read and write** (MemRead = MemWrite = 1, same address):
  - ReadData shows the old contents before the edge.
  - It shows the new contents after the edge, with no further input change.
- **Outputs during and after reset**:
  - ReadData = 0 while reset is low.
  - After reset releases, every in-range load returns 0 until written.
  - Pass-through outputs simply track their inputs.
- **Reset mid-operation**: a store presented on the same edge as reset low is lost.
- **No handshake**: one access per cycle, controlled purely by MemRead/MemWrite levels.

## Test plan
- **Store then load at 0x10**
  - Stimulus: ALUResult=0x10, WriteData=0xDEADBEEFDEADBEEF, MemWrite=1 for one edge; next cycle MemWrite=0, MemRead=1, Rd=13.
  - Response: ReadData=0xDEADBEEFDEADBEEF, RdOut=13, BranchTakenOut=0.
- **Store/load at 0x20**
  - Stimulus: write 0x1234567890ABCDEF, then load.
  - Response: ReadData=0x1234567890ABCDEF; entry 0x10 unchanged.
- **Branch pass-through**
  - Stimulus: ALUResult=0x30, BranchTaken=1, MemRead=0.
  - Response: ReadData=0, BranchTakenOut=1, ALUResultOut=0x30.
- **Boundaries**
  - Stimulus: write 0xAAAAAAAAAAAAAAAA at 0x0 and 0x5555555555555555 at 0x1FF8, then load each.
  - Response: each load returns its own value.
  - Stimulus: load at 0x2000 (MemRead=1).
  - Response: ReadData=0; a store at 0x2000 must not alter entry 0.
- **Reset clears memory**
  - Stimulus: write 0xFFFFFFFFFFFFFFFF at 0x10; pulse reset low for one edge; then load 0x10.
  - Response: ReadData=0.
- **Misaligned and same-cycle read/write**
  - Stimulus: store at 0x13, then load at 0x10.
  - Response: the load returns the stored value.
  - Stimulus: MemRead=MemWrite=1 at the same address.
  - Response: old value before the edge, new value after it.
